register_scoreboard: RTL and testbench
======================================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port issueValid, input, 1: ID instruction requests advance to EX this cycle.
REQ-004 SHALL have port issueWbEn, input, 1: issuing instruction writes a register.
REQ-005 SHALL have port issueDest, input, 4: issuing instruction destination register.
REQ-006 SHALL have port issueMemRead, input, 1: issuing instruction is a load.
REQ-007 SHALL have port issueSetsFlags, input, 1: issuing instruction updates status flags.
REQ-008 SHALL have port flush, input, 1: branch taken; ID instruction killed.
REQ-009 SHALL have ports src1, src2, input, 4 each: ID-stage source registers.
REQ-010 SHALL have ports src1Used, src2Used, readsFlags, input, 1 each: ID operand and condition-flag usage.
REQ-011 SHALL have port retireValid, input, 1: WB stage completes an instruction this cycle.
REQ-012 SHALL have ports retireWbEn, input, 1, and retireDest, input, 4: WB register write and its destination.
REQ-013 SHALL have port retireSetsFlags, input, 1: WB-stage instruction updated flags.
REQ-014 SHALL have port hazard, output, 1: stall ID/IF and insert bubble.
REQ-015 SHALL have port issueAccepted, output, 1: issueValid && !hazard && !flush.
REQ-016 SHALL have port scoreboardError, output, 1: sticky overflow/underflow indicator.

Function
REQ-017 SHALL hold per register r0..r15 a 2-bit pending count plus one 2-bit flags-pending count; max 3 in flight (EX, MEM, WB).
REQ-018 hazard SHALL be combinational from current state and ID inputs; zero added latency.
REQ-019 Base hazard: (src1Used && count[src1]!=0) || (src2Used && count[src2]!=0) || (readsFlags && flagsCount!=0).
REQ-020 On issueAccepted && issueWbEn: count[issueDest] +1 at next edge; likewise flagsCount for issueSetsFlags.
REQ-021 On retireValid && retireWbEn: count[retireDest] -1 at next edge; likewise flagsCount for retireSetsFlags.
REQ-022 Simultaneous increment and decrement of same counter SHALL leave it unchanged.
REQ-023 Increment at 3 SHALL saturate at 3 and set scoreboardError; decrement at 0 SHALL hold 0 and set scoreboardError.
REQ-024 flush SHALL block increment that cycle; retire updates still apply; hazard still driven.
REQ-025 Issue and retire on different registers same cycle SHALL both apply.
REQ-026 hazard SHALL not affect retire path; stalled instruction re-evaluates each cycle.

Reset
REQ-027 Asserting rst SHALL immediately clear all counters, flagsCount, scoreboardError; hazard=0 when no sources used.
REQ-028 Reset mid-operation SHALL discard all in-flight tracking; retires arriving after reset at 0 set scoreboardError per REQ-023.

Configuration
REQ-029 Macro SCOREBOARD_FORWARDING_EN SHALL select hazard policy.
REQ-030 With SCOREBOARD_FORWARDING_EN: additional EX-load register (valid, dest) loaded each edge from issueAccepted && issueWbEn && issueMemRead, cleared otherwise; register hazard only when used source equals EX-load dest with valid set; flags hazard unchanged (REQ-019).
REQ-031 Without SCOREBOARD_FORWARDING_EN: hazard per REQ-019 only; EX-load register absent.

Verification
REQ-032 Reset, issue ADD r3 (issueValid, WbEn, dest 3); next cycle src1=3 used -> hazard=1 (macro off), 0 (macro on); count[3]=1.
REQ-033 Macro on: issue LDR r5; next cycle src2=5 used -> hazard=1, issueAccepted=0; following cycle (load in MEM) -> hazard=0.
REQ-034 Issue r7 and retire r7 same cycle with count[7]=1 -> count[7] stays 1; retire r7 once more -> 0, hazard clears.
REQ-035 flush=1 with issueValid, dest 2 -> issueAccepted=0, count[2] stays 0; retire r2 at count 0 -> scoreboardError=1, sticky until rst.
REQ-036 Issue CMP (SetsFlags), then readsFlags=1 -> hazard=1 until retireSetsFlags; assert rst mid-stream -> all counts 0, hazard=0 immediately.

Source files
------------

// File: rtl/register_scoreboard.sv
// Register/flags scoreboard for ID-stage interlocks over a 3-deep EX/MEM/WB window.
// Define SCOREBOARD_FORWARDING_EN to stall register sources only on a load still in EX.
module register_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       issueValid,
    input  logic       issueWbEn,
    input  logic [3:0] issueDest,
    input  logic       issueMemRead,
    input  logic       issueSetsFlags,
    input  logic       flush,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       src1Used,
    input  logic       src2Used,
    input  logic       readsFlags,
    input  logic       retireValid,
    input  logic       retireWbEn,
    input  logic [3:0] retireDest,
    input  logic       retireSetsFlags,
    output logic       hazard,
    output logic       issueAccepted,
    output logic       scoreboardError
);

    // {error, next_count}: saturate at 3, hold at 0, cancel on simultaneous inc/dec
    function automatic logic [2:0] step_count(input logic [1:0] cnt, input logic inc,
                                              input logic dec);
        logic [2:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == 2'd3) res = {1'b1, cnt};
            else             res = {1'b0, cnt + 2'd1};
        end else if (dec && !inc) begin
            if (cnt == 2'd0) res = {1'b1, cnt};
            else             res = {1'b0, cnt - 2'd1};
        end
        return res;
    endfunction

    logic [15:0][1:0] cnt_all;
    logic [15:0]      reg_err;
    logic [1:0]       flags_cnt;
    logic [2:0]       flags_res;
    logic             err_q;
    logic             issue_fire;
    logic             retire_fire;
    logic             flags_hz;
    logic             reg_hz;

    assign issue_fire  = issueAccepted && issueWbEn;
    assign retire_fire = retireValid && retireWbEn;

    for (genvar g = 0; g < 16; g++) begin : g_reg
        logic [1:0] cnt;
        logic [2:0] res;
        assign res = step_count(cnt, issue_fire && (issueDest == 4'(g)),
                                retire_fire && (retireDest == 4'(g)));
        assign reg_err[g] = res[2];
        assign cnt_all[g] = cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt <= '0;
            else     cnt <= res[1:0];
        end
    end

    assign flags_res = step_count(flags_cnt, issueAccepted && issueSetsFlags,
                                  retireValid && retireSetsFlags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            flags_cnt <= flags_res[1:0];
            err_q     <= err_q | (|reg_err) | flags_res[2];
        end
    end

    assign flags_hz = readsFlags && (flags_cnt != 2'd0);

`ifdef SCOREBOARD_FORWARDING_EN
    logic       ex_load_valid;
    logic [3:0] ex_load_dest;

    // Only a load in EX cannot be forwarded; a stall loads a bubble here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_load_valid <= 1'b0;
            ex_load_dest  <= '0;
        end else begin
            ex_load_valid <= issue_fire && issueMemRead;
            ex_load_dest  <= issueDest;
        end
    end

    assign reg_hz = ex_load_valid && ((src1Used && (src1 == ex_load_dest)) ||
                                      (src2Used && (src2 == ex_load_dest)));
`else
    assign reg_hz = (src1Used && (cnt_all[src1] != 2'd0)) ||
                    (src2Used && (cnt_all[src2] != 2'd0));
`endif

    assign hazard          = reg_hz || flags_hz;
    assign issueAccepted   = issueValid && !hazard && !flush;
    assign scoreboardError = err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard; follows SCOREBOARD_FORWARDING_EN.
module tb_register_scoreboard;

`ifdef SCOREBOARD_FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       issueValid;
    logic       issueWbEn;
    logic [3:0] issueDest;
    logic       issueMemRead;
    logic       issueSetsFlags;
    logic       flush;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       src1Used;
    logic       src2Used;
    logic       readsFlags;
    logic       retireValid;
    logic       retireWbEn;
    logic [3:0] retireDest;
    logic       retireSetsFlags;
    logic       hazard;
    logic       issueAccepted;
    logic       scoreboardError;

    int n_checks;
    int n_errors;

    register_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issueValid     (issueValid),
        .issueWbEn      (issueWbEn),
        .issueDest      (issueDest),
        .issueMemRead   (issueMemRead),
        .issueSetsFlags (issueSetsFlags),
        .flush          (flush),
        .src1           (src1),
        .src2           (src2),
        .src1Used       (src1Used),
        .src2Used       (src2Used),
        .readsFlags     (readsFlags),
        .retireValid    (retireValid),
        .retireWbEn     (retireWbEn),
        .retireDest     (retireDest),
        .retireSetsFlags(retireSetsFlags),
        .hazard         (hazard),
        .issueAccepted  (issueAccepted),
        .scoreboardError(scoreboardError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issueValid = 0; issueWbEn = 0; issueDest = 0; issueMemRead = 0;
        issueSetsFlags = 0; flush = 0; src1 = 0; src2 = 0; src1Used = 0;
        src2Used = 0; readsFlags = 0; retireValid = 0; retireWbEn = 0;
        retireDest = 0; retireSetsFlags = 0;
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] dest, input logic mem, input logic flags,
                         input logic wb);
        issueValid = 1; issueWbEn = wb; issueDest = dest;
        issueMemRead = mem; issueSetsFlags = flags;
    endtask

    task automatic retire(input logic [3:0] dest, input logic wb, input logic flags);
        retireValid = 1; retireWbEn = wb; retireDest = dest; retireSetsFlags = flags;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1;
        #2;
        check("reset_hazard", hazard, 0);
        check("reset_error", scoreboardError, 0);
        check("reset_accept", issueAccepted, 0);
        step(); step();
        rst = 0;

        // ADD r3, then dependent read of r3
        issue(4'd3, 0, 0, 1);
        #1 check("add_accept", issueAccepted, 1);
        step();
        idle();
        src1 = 3; src1Used = 1; issueValid = 1;
        #1 check("raw_r3_hazard", hazard, !FWD);
        check("raw_r3_accept", issueAccepted, FWD);
        step();
        issueValid = 0;
        retire(4'd3, 1, 0);
        step();
        retireValid = 0;
        #1 check("r3_retired_hazard", hazard, 0);
        idle();

        // LDR r5, load-use stall
        issue(4'd5, 1, 0, 1);
        step();
        idle();
        src2 = 5; src2Used = 1; issueValid = 1;
        #1 check("load_use_hazard", hazard, 1);
        check("load_use_accept", issueAccepted, 0);
        step();
        #1 check("load_in_mem_hazard", hazard, !FWD);
        idle();
        retire(4'd5, 1, 0);
        step();
        idle();
        src2 = 5; src2Used = 1;
        #1 check("r5_retired_hazard", hazard, 0);
        idle();

        // simultaneous issue/retire of r7 cancels
        issue(4'd7, 0, 0, 1);
        step();
        retire(4'd7, 1, 0);
        step();
        idle();
        src1 = 7; src1Used = 1;
        #1 check("r7_inc_dec_hazard", hazard, !FWD);
        retire(4'd7, 1, 0);
        step();
        retireValid = 0;
        #1 check("r7_clear_hazard", hazard, 0);
        check("r7_no_error", scoreboardError, 0);
        idle();

        // issue r10 while retiring r9
        issue(4'd9, 0, 0, 1);
        step();
        issue(4'd10, 0, 0, 1);
        retire(4'd9, 1, 0);
        step();
        idle();
        src1 = 9; src1Used = 1; src2 = 10; src2Used = 0;
        #1 check("r9_retired_hazard", hazard, 0);
        src1Used = 0; src2Used = 1;
        #1 check("r10_pending_hazard", hazard, !FWD);
        idle();
        retire(4'd10, 1, 0);
        step();
        idle();

        // CMP, then flags reader stalls until flag retire
        issue(4'd0, 0, 1, 0);
        step();
        idle();
        readsFlags = 1; issueValid = 1;
        #1 check("flags_hazard", hazard, 1);
        check("flags_accept", issueAccepted, 0);
        step(); step();
        #1 check("flags_hazard_held", hazard, 1);
        retire(4'd0, 0, 1);
        step();
        retireValid = 0; retireSetsFlags = 0;
        #1 check("flags_cleared", hazard, 0);
        check("flags_no_error", scoreboardError, 0);
        idle();

        // saturation of r1 at the fourth in-flight write
        for (int unsigned i = 0; i < 3; i++) begin
            issue(4'd1, 0, 0, 1);
            step();
        end
        idle();
        #1 check("r1_three_no_error", scoreboardError, 0);
        issue(4'd1, 0, 0, 1);
        step();
        idle();
        #1 check("r1_overflow_error", scoreboardError, 1);

        // async reset mid-stream with a flags write outstanding
        issue(4'd0, 0, 1, 0);
        step();
        idle();
        readsFlags = 1; src1 = 1; src1Used = 1;
        #1 check("pre_reset_hazard", hazard, 1);
        rst = 1;
        #1 check("async_reset_hazard", hazard, 0);
        check("async_reset_error", scoreboardError, 0);
        step();
        rst = 0;
        idle();

        // flush blocks the increment; retire of r2 then underflows
        issue(4'd2, 1, 0, 1);
        flush = 1;
        #1 check("flush_accept", issueAccepted, 0);
        step();
        idle();
        src1 = 2; src1Used = 1;
        #1 check("flush_no_track", hazard, 0);
        retire(4'd2, 1, 0);
        step();
        idle();
        #1 check("underflow_error", scoreboardError, 1);
        step(); step(); step();
        check("error_sticky", scoreboardError, 1);
        rst = 1;
        #1 check("error_reset", scoreboardError, 0);
        step();
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
